rr_grant_scheduler: RTL and testbench



---
 rtl/rr_grant_scheduler_pkg.sv | 13 +
 rtl/DecoderVRTL.sv | 14 +
 rtl/rr_grant_scheduler.sv | 87 ++++++++
 tb/tb_rr_grant_scheduler.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/rr_grant_scheduler_pkg.sv
// Shared types and default sizing for the round-robin grant scheduler.
package rr_grant_scheduler_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int DEFAULT_M       = 3;
    localparam int DEFAULT_TIMEOUT = 16;
    localparam int DEFAULT_TW      = 8;

endpackage

// File: rtl/DecoderVRTL.sv
// Binary-to-one-hot decoder used to drive downstream select lines.
module DecoderVRTL #(
    parameter int m = 3
) (
    input  logic [m-1:0]        sel,
    output logic [(1<<m)-1:0]   onehot
);

    always_comb begin
        onehot      = '0;
        onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin arbiter that holds one grant until done or a watchdog expiry,
// exposing the winner as a binary id and a gated one-hot select.
module rr_grant_scheduler
    import rr_grant_scheduler_pkg::*;
#(
    parameter int M       = DEFAULT_M,
    parameter int N       = 1 << M,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int TW      = DEFAULT_TW
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         done,
    output logic         grant_val,
    output logic [M-1:0] grant_id,
    output logic [N-1:0] grant_onehot,
    output logic         timeout_err
);

    state_t        state;
    logic [M-1:0]  ptr;
    logic [TW-1:0] cnt;
    logic [TW-1:0] cnt_next;
    logic [M-1:0]  idx;
    logic [M-1:0]  pick;
    logic [N-1:0]  decoded;

    // Scan from ptr upward with M-bit wraparound; the descending loop leaves
    // the nearest set requester (smallest circular offset) in pick.
    always_comb begin
        idx  = '0;
        pick = ptr;
        for (int i = N - 1; i >= 0; i--) begin
            idx = ptr + M'(i);
            if (req[idx]) begin
                pick = idx;
            end
        end
    end

    assign cnt_next = cnt + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            cnt         <= '0;
            grant_id    <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant_id <= pick;
                        cnt      <= '0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    // cnt_next is the number of the BUSY cycle now ending.
                    cnt <= cnt_next;
                    if (done) begin
                        state <= IDLE;
                        ptr   <= grant_id + 1'b1;
                    end else if (cnt_next == TW'(TIMEOUT)) begin
                        state       <= IDLE;
                        ptr         <= grant_id + 1'b1;
                        timeout_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign grant_val = (state == BUSY);

    DecoderVRTL #(.m(M)) u_decoder (
        .sel    (grant_id),
        .onehot (decoded)
    );

    assign grant_onehot = decoded & {N{grant_val}};

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Directed bench for rr_grant_scheduler: inputs change and outputs are
// sampled on the falling edge, half a period away from the active edge.
module tb_rr_grant_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] req;
    logic       done;
    logic       grant_val;
    logic [2:0] grant_id;
    logic [7:0] grant_onehot;
    logic       timeout_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rr_grant_scheduler #(.M(3), .TIMEOUT(16), .TW(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .done         (done),
        .grant_val    (grant_val),
        .grant_id     (grant_id),
        .grant_onehot (grant_onehot),
        .timeout_err  (timeout_err)
    );

    task automatic test_reset();
        reset = 1'b1;
        req   = 8'h00;
        done  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++; if (grant_val !== 1'b0) begin bad++; $display("[TB] FAIL reset_val got=%b want=0", grant_val); end
        total++; if (grant_id !== 3'd0) begin bad++; $display("[TB] FAIL reset_id got=%0d want=0", grant_id); end
        total++; if (grant_onehot !== 8'h00) begin bad++; $display("[TB] FAIL reset_onehot got=%h want=00", grant_onehot); end
        total++; if (timeout_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_terr got=%b want=0", timeout_err); end
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_grant();
        @(negedge clk);
        req = 8'h04;
        @(negedge clk);
        total++; if (grant_val !== 1'b1 || grant_id !== 3'd2) begin bad++; $display("[TB] FAIL midrst_pre got=%b/%0d want=1/2", grant_val, grant_id); end
        #2 reset = 1'b1;
        #1;
        total++; if (grant_val !== 1'b0) begin bad++; $display("[TB] FAIL midrst_val got=%b want=0", grant_val); end
        total++; if (grant_onehot !== 8'h00) begin bad++; $display("[TB] FAIL midrst_onehot got=%h want=00", grant_onehot); end
        total++; if (timeout_err !== 1'b0) begin bad++; $display("[TB] FAIL midrst_terr got=%b want=0", timeout_err); end
        @(negedge clk);
        reset = 1'b0;
        req   = 8'h01;
        @(negedge clk);
        total++; if (grant_val !== 1'b1 || grant_id !== 3'd0) begin bad++; $display("[TB] FAIL midrst_regrant got=%b/%0d want=1/0", grant_val, grant_id); end
        total++; if (grant_onehot !== 8'h01) begin bad++; $display("[TB] FAIL midrst_regrant_onehot got=%h want=01", grant_onehot); end
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        req  = 8'h00;
        total++; if (grant_val !== 1'b0) begin bad++; $display("[TB] FAIL midrst_release got=%b want=0", grant_val); end
    endtask

    task automatic test_single();
        req = 8'h04;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            total++; if (grant_val !== 1'b1 || grant_id !== 3'd2 || grant_onehot !== 8'h04) begin
                bad++; $display("[TB] FAIL single_busy cyc=%0d got=%b/%0d/%h want=1/2/04", c, grant_val, grant_id, grant_onehot);
            end
            if (c == 3) done = 1'b1;
        end
        @(negedge clk);
        done = 1'b0;
        total++; if (grant_val !== 1'b0 || grant_onehot !== 8'h00) begin bad++; $display("[TB] FAIL single_bubble got=%b/%h want=0/00", grant_val, grant_onehot); end
        total++; if (grant_id !== 3'd2) begin bad++; $display("[TB] FAIL single_hold_id got=%0d want=2", grant_id); end
        req = 8'h0C;
        @(negedge clk);
        total++; if (grant_val !== 1'b1 || grant_id !== 3'd3) begin bad++; $display("[TB] FAIL single_next got=%b/%0d want=1/3", grant_val, grant_id); end
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        req  = 8'h00;
    endtask

    task automatic test_contention();
        logic [7:0] seen;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req   = 8'hFF;
        seen  = 8'h00;
        for (int g = 0; g <= 8; g++) begin
            @(negedge clk);
            total++; if (grant_val !== 1'b1 || grant_id !== 3'(g % 8)) begin
                bad++; $display("[TB] FAIL contend_id g=%0d got=%b/%0d want=1/%0d", g, grant_val, grant_id, g % 8);
            end
            if (g < 8) seen = seen | (8'h01 << grant_id);
            done = 1'b1;
            @(negedge clk);
            done = 1'b0;
            total++; if (grant_val !== 1'b0) begin bad++; $display("[TB] FAIL contend_bubble g=%0d got=%b want=0", g, grant_val); end
        end
        req = 8'h00;
        total++; if (seen !== 8'hFF) begin bad++; $display("[TB] FAIL contend_fair got=%h want=ff", seen); end
    endtask

    task automatic test_wrap();
        req = 8'h40;
        @(negedge clk);
        total++; if (grant_id !== 3'd6) begin bad++; $display("[TB] FAIL wrap_id6 got=%0d want=6", grant_id); end
        done = 1'b1;
        req  = 8'h81;
        @(negedge clk);
        done = 1'b0;
        @(negedge clk);
        total++; if (grant_val !== 1'b1 || grant_id !== 3'd7) begin bad++; $display("[TB] FAIL wrap_id7 got=%b/%0d want=1/7", grant_val, grant_id); end
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        @(negedge clk);
        total++; if (grant_val !== 1'b1 || grant_id !== 3'd0) begin bad++; $display("[TB] FAIL wrap_id0 got=%b/%0d want=1/0", grant_val, grant_id); end
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        req  = 8'h00;
    endtask

    task automatic test_done_idle();
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        total++; if (grant_val !== 1'b0 || timeout_err !== 1'b0) begin bad++; $display("[TB] FAIL done_idle got=%b/%b want=0/0", grant_val, timeout_err); end
    endtask

    task automatic test_watchdog();
        req = 8'h02;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            total++; if (grant_val !== 1'b1 || grant_id !== 3'd1 || timeout_err !== 1'b0) begin
                bad++; $display("[TB] FAIL wdog_hold cyc=%0d got=%b/%0d/%b want=1/1/0", c, grant_val, grant_id, timeout_err);
            end
            if (c == 1) req = 8'h00;
        end
        @(negedge clk);
        total++; if (grant_val !== 1'b0 || timeout_err !== 1'b1) begin bad++; $display("[TB] FAIL wdog_expire got=%b/%b want=0/1", grant_val, timeout_err); end
        req = 8'h03;
        @(negedge clk);
        total++; if (grant_val !== 1'b1 || grant_id !== 3'd0 || timeout_err !== 1'b0) begin
            bad++; $display("[TB] FAIL wdog_next got=%b/%0d/%b want=1/0/0", grant_val, grant_id, timeout_err);
        end
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        req  = 8'h00;
    endtask

    task automatic test_done_at_timeout();
        req = 8'h02;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            total++; if (grant_val !== 1'b1 || grant_id !== 3'd1) begin
                bad++; $display("[TB] FAIL tie_hold cyc=%0d got=%b/%0d want=1/1", c, grant_val, grant_id);
            end
            if (c == 1) req = 8'h00;
            if (c == 16) done = 1'b1;
        end
        @(negedge clk);
        done = 1'b0;
        total++; if (grant_val !== 1'b0 || timeout_err !== 1'b0) begin bad++; $display("[TB] FAIL tie_release got=%b/%b want=0/0", grant_val, timeout_err); end
        @(negedge clk);
        total++; if (timeout_err !== 1'b0) begin bad++; $display("[TB] FAIL tie_terr_late got=%b want=0", timeout_err); end
    endtask

    initial begin
        test_reset();
        test_reset_mid_grant();
        test_single();
        test_contention();
        test_wrap();
        test_done_idle();
        test_watchdog();
        test_done_at_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
